// File: rtl/trip_calc_pkg.sv
`default_nettype none
// ============================================================================
// Package : trip_calc_pkg
// Brief   : Shared state encoding and widths for the trip interval calculator.
// Revision: 1.0
// ============================================================================
package trip_calc_pkg;

    localparam int COUNT_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIFF   = 3'd1,
        DIVIDE = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } trip_calc_state_t;

endpackage
`default_nettype wire

// File: rtl/trip_interval_calc_if.sv
`default_nettype none
// ============================================================================
// Interface : trip_interval_calc_if
// Brief     : Trip counts in, rate result out on a valid/ready port.
// Revision  : 1.0
// ============================================================================
interface trip_interval_calc_if #(
    parameter int NUM_W = 48
) ();
    import trip_calc_pkg::*;

    logic               hasTripped;
    logic [COUNT_W-1:0] theCount1;
    logic [COUNT_W-1:0] theCount2;
    logic               result_valid;
    logic               result_ready;
    logic [NUM_W-1:0]   quotient;
    logic [COUNT_W-1:0] delta;
    logic               order;
    logic               div_by_zero;
    logic               busy;

    modport master (
        output hasTripped,
        output theCount1,
        output theCount2,
        output result_ready,
        input  result_valid,
        input  quotient,
        input  delta,
        input  order,
        input  div_by_zero,
        input  busy
    );

    modport slave (
        input  hasTripped,
        input  theCount1,
        input  theCount2,
        input  result_ready,
        output result_valid,
        output quotient,
        output delta,
        output order,
        output div_by_zero,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider
// Brief   : Restoring divider, one quotient bit per cycle, MSB first.
// Revision: 1.0
// ============================================================================
module seq_divider #(
    parameter int NUM_W = 48,
    parameter int DEN_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start_i,
    input  wire logic [NUM_W-1:0] dividend_i,
    input  wire logic [DEN_W-1:0] divisor_i,
    output logic                  done_o,
    output logic [NUM_W-1:0]      quotient_o,
    output logic [DEN_W:0]        remainder_o
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             running_q;
    logic             done_q;
    logic [NUM_W-1:0] quo_q;
    logic [DEN_W:0]   rem_q;
    logic [DEN_W-1:0] div_q;

    logic [NUM_W-1:0] w_quo_src;
    logic [DEN_W-1:0] w_rem_src;
    logic [DEN_W-1:0] w_div;
    logic [DEN_W:0]   w_shift;
    logic [DEN_W:0]   w_rem_n;
    logic             w_ge;
    logic [NUM_W-1:0] w_quo_n;

    // The start cycle already retires the first quotient bit, so the divide
    // occupies exactly NUM_W cycles from start to the done pulse edge.
    always_comb begin
        w_quo_src = start_i ? dividend_i : quo_q;
        w_rem_src = start_i ? '0 : rem_q[DEN_W-1:0];
        w_div     = start_i ? divisor_i : div_q;
        w_shift   = {w_rem_src, w_quo_src[NUM_W-1]};
        w_ge      = (w_shift >= {1'b0, w_div});
        w_rem_n   = w_ge ? (w_shift - {1'b0, w_div}) : w_shift;
        w_quo_n   = (w_quo_src << 1) | NUM_W'(w_ge);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                quo_q     <= w_quo_n;
                rem_q     <= w_rem_n;
                div_q     <= divisor_i;
                cnt_q     <= CNT_W'(NUM_W - 1);
                running_q <= (NUM_W > 1);
                done_q    <= (NUM_W == 1);
            end else if (running_q) begin
                quo_q <= w_quo_n;
                rem_q <= w_rem_n;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/trip_interval_calc.sv
`default_nettype none
// ============================================================================
// Module  : trip_interval_calc
// Brief   : rate = NUMERATOR / |count2 - count1| on each hasTripped rising edge.
//           Define TRIP_CALC_ROUND_EN for round-half-up instead of floor.
// Revision: 1.0
// ============================================================================
module trip_interval_calc
    import trip_calc_pkg::*;
#(
    parameter int               NUM_W     = 48,
    parameter logic [NUM_W-1:0] NUMERATOR = 48'd50_000_000
) (
    input wire logic            CLK,
    input wire logic            RST,
    trip_interval_calc_if.slave bus
);

    trip_calc_state_t   state_q;
    logic               trip_prev_q;
    logic [COUNT_W-1:0] count1_q;
    logic [COUNT_W-1:0] count2_q;
    logic [COUNT_W-1:0] delta_q;
    logic               order_q;
    logic [NUM_W-1:0]   quotient_q;
    logic               dz_q;
    logic               valid_q;

    logic               w_trig;
    logic               w_order;
    logic [COUNT_W-1:0] w_delta;
    logic               w_div_start;
    logic               w_div_done;
    logic [NUM_W-1:0]   w_div_quo;
    logic [COUNT_W:0]   w_div_rem;

    always_comb begin
        w_trig      = bus.hasTripped && !trip_prev_q;
        w_order     = (count2_q >= count1_q);
        w_delta     = w_order ? (count2_q - count1_q) : (count1_q - count2_q);
        w_div_start = (state_q == DIFF) && (w_delta != '0);
    end

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (COUNT_W)
    ) u_div (
        .clk         (CLK),
        .rst         (RST),
        .start_i     (w_div_start),
        .dividend_i  (NUMERATOR),
        .divisor_i   (w_delta),
        .done_o      (w_div_done),
        .quotient_o  (w_div_quo),
        .remainder_o (w_div_rem)
    );

`ifdef TRIP_CALC_ROUND_EN
    logic w_round_up;
    assign w_round_up = ({w_div_rem, 1'b0} >= {2'b00, delta_q}) && (quotient_q != '1);
`else
    logic w_unused_rem;
    assign w_unused_rem = ^w_div_rem;
`endif

    // The edge-detect register tracks hasTripped in every state, so edges seen
    // while busy are consumed rather than replayed once back in IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            trip_prev_q <= 1'b1;
            count1_q    <= '0;
            count2_q    <= '0;
            delta_q     <= '0;
            order_q     <= 1'b0;
            quotient_q  <= '0;
            dz_q        <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            trip_prev_q <= bus.hasTripped;
            case (state_q)
                IDLE: begin
                    if (w_trig) begin
                        count1_q <= bus.theCount1;
                        count2_q <= bus.theCount2;
                        state_q  <= DIFF;
                    end
                end
                DIFF: begin
                    delta_q <= w_delta;
                    order_q <= w_order;
                    if (w_delta == '0) begin
                        quotient_q <= '1;
                        dz_q       <= 1'b1;
                        valid_q    <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        dz_q    <= 1'b0;
                        state_q <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (w_div_done) begin
                        quotient_q <= w_div_quo;
`ifdef TRIP_CALC_ROUND_EN
                        state_q    <= ROUND;
`else
                        valid_q    <= 1'b1;
                        state_q    <= DONE;
`endif
                    end
                end
`ifdef TRIP_CALC_ROUND_EN
                ROUND: begin
                    if (w_round_up) begin
                        quotient_q <= quotient_q + NUM_W'(1);
                    end
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
`endif
                DONE: begin
                    if (bus.result_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.result_valid = valid_q;
    assign bus.quotient     = quotient_q;
    assign bus.delta        = delta_q;
    assign bus.order        = order_q;
    assign bus.div_by_zero  = dz_q;
    assign bus.busy         = (state_q != IDLE);

endmodule
`default_nettype wire
